// File: rtl/aes_seq_pkg.sv
// Shared definitions for the serial AES-128 round sequencer and its key-expansion neighbour:
// FSM encodings, round/phase constants and the GF(2^8) doubling used for Rcon.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROUND  = 2'd2,
        UNLOAD = 2'd3
    } seq_state_t;

    localparam int          NUM_ROUNDS   = 10;
    localparam int          ROUND_CYCLES = 20;
    localparam int          DATA_CYCLES  = 16;
    localparam logic [7:0]  RCON_INIT    = 8'h01;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: load restarts the sequence at 01, step advances it by xtime.
module aes_rcon_gen
    import aes_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] r_rcon;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_rcon <= RCON_INIT;
        end else if (step) begin
            r_rcon <= xtime(r_rcon);
        end
    end

    assign rcon = r_rcon;

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for the 8-bit serial AES-128 datapath: byte-stream load with initial
// AddRoundKey, ten 20-cycle rounds sharing one S-box with the key schedule, then byte unload.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS   = aes_seq_pkg::NUM_ROUNDS,
    parameter int ROUND_CYCLES = aes_seq_pkg::ROUND_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       byte_en,
    output logic       ark_en,
    output logic       sbox_sel,
    output logic       mix_en,
    output logic       key_step,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);
    import aes_seq_pkg::*;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [4:0] LAST_PHASE = 5'(ROUND_CYCLES - 1);
    localparam logic [4:0] DATA_PH    = 5'(DATA_CYCLES);

    seq_state_t r_state, w_state_next;
    logic [3:0] r_byte_cnt, w_byte_cnt_next;
    logic [4:0] r_phase, w_phase_next;
    logic [3:0] r_round, w_round_next;
    logic       r_done, w_done_next;
    logic       w_rcon_load, w_rcon_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_cnt <= 4'd0;
            r_phase    <= 5'd0;
            r_round    <= 4'd0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_phase    <= w_phase_next;
            r_round    <= w_round_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_phase_next    = r_phase;
        w_round_next    = r_round;
        w_done_next     = 1'b0;
        w_rcon_load     = 1'b0;
        w_rcon_step     = 1'b0;
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        byte_en         = 1'b0;
        ark_en          = 1'b0;
        sbox_sel        = 1'b0;
        mix_en          = 1'b0;
        key_step        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next    = LOAD;
                    w_byte_cnt_next = 4'd0;
                    w_phase_next    = 5'd0;
                    w_round_next    = 4'd0;
                    w_rcon_load     = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    byte_en         = 1'b1;
                    ark_en          = 1'b1;
                    key_step        = 1'b1;
                    w_byte_cnt_next = r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'hF) begin
                        w_state_next = ROUND;
                        w_round_next = 4'd1;
                        w_phase_next = 5'd0;
                    end
                end
            end
            ROUND: begin
                // Data phases own the S-box; the tail phases lend it to the key schedule.
                if (r_phase < DATA_PH) begin
                    byte_en  = 1'b1;
                    ark_en   = 1'b1;
                    key_step = 1'b1;
                    mix_en   = (r_phase[1:0] == 2'd3) && (r_round < LAST_ROUND);
                end else begin
                    sbox_sel = 1'b1;
                end
                if (r_phase == LAST_PHASE) begin
                    w_phase_next = 5'd0;
                    if (r_round < LAST_ROUND) begin
                        w_round_next = r_round + 4'd1;
                        w_rcon_step  = 1'b1;
                    end else begin
                        w_state_next    = UNLOAD;
                        w_byte_cnt_next = 4'd0;
                    end
                end else begin
                    w_phase_next = r_phase + 5'd1;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    byte_en         = 1'b1;
                    w_byte_cnt_next = r_byte_cnt + 4'd1;
                    if (r_byte_cnt == 4'hF) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    aes_rcon_gen u_rcon (
        .clk  (clk),
        .rst  (rst),
        .load (w_rcon_load),
        .step (w_rcon_step),
        .rcon (rcon)
    );

    assign round = r_round;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized self-checking bench for aes_round_sequencer against a block-level timing model.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, byte_en, ark_en, sbox_sel, mix_en, key_step, busy, done;
    logic [7:0] rcon;
    logic [3:0] round;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .byte_en   (byte_en),
        .ark_en    (ark_en),
        .sbox_sel  (sbox_sel),
        .mix_en    (mix_en),
        .key_step  (key_step),
        .rcon      (rcon),
        .round     (round),
        .busy      (busy),
        .done      (done)
    );

    // Round constant seen during each round number (index 0 = before the rounds start).
    localparam logic [7:0] RCON_TAB [0:10] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit checking = 1'b0;

    // Block-level model: mode 0 idle, 1 loading, 2 rounds, 3 unloading; m_n counts progress.
    int m_mode = 0;
    int m_n = 0;
    bit m_done = 1'b0;
    bit m_fin = 1'b0;

    int cfg_in = 0;
    int cfg_out = 0;
    bit cfg_noise = 1'b0;
    bit req_start = 1'b0;
    int stall_left = 0;
    int pat_idx = 0;

    int t_last_in = 0;
    int t_first_out = -1;
    int mix_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_mode <= 0; m_n <= 0; m_done <= 1'b0; m_fin <= 1'b0;
        end else begin
            m_done <= 1'b0;
            case (m_mode)
                0: if (start) begin m_mode <= 1; m_n <= 0; m_fin <= 1'b0; end
                1: if (in_valid) begin
                    if (m_n == 15) begin m_mode <= 2; m_n <= 0; end
                    else m_n <= m_n + 1;
                end
                2: if (m_n == 199) begin m_mode <= 3; m_n <= 0; end
                   else m_n <= m_n + 1;
                3: if (out_ready) begin
                    if (m_n == 15) begin
                        m_mode <= 0; m_n <= 0; m_done <= 1'b1; m_fin <= 1'b1;
                    end else m_n <= m_n + 1;
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Stimulus driver, updated just after each rising edge.
    always @(posedge clk) begin
        #2;
        case (cfg_in)
            0: in_valid = 1'b1;
            1: in_valid = ($urandom % 4) != 0;
            default: begin
                if (m_mode == 1 && m_n == 7 && stall_left > 0) begin
                    in_valid = 1'b0;
                    stall_left--;
                end else in_valid = 1'b1;
            end
        endcase
        case (cfg_out)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom % 3) != 0;
            default: begin
                if (m_mode == 3) begin
                    out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                    pat_idx++;
                end else out_ready = 1'b1;
            end
        endcase
        if (m_mode == 0 && req_start && !rst) begin
            start = 1'b1;
            req_start = 1'b0;
        end else if (m_mode != 0 && cfg_noise) begin
            start = ($urandom % 2) != 0;
        end else begin
            start = 1'b0;
        end
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        int ph;
        int e_round;
        bit e_data, e_load;
        if (checking) begin
            ph      = m_n % 20;
            e_round = (m_mode == 0) ? (m_fin ? 10 : 0) :
                      (m_mode == 1) ? 0 : (m_mode == 2) ? (m_n / 20 + 1) : 10;
            e_data  = (m_mode == 2) && (ph < 16);
            e_load  = (m_mode == 1) && in_valid;
            chk("busy",      busy,      m_mode != 0);
            chk("in_ready",  in_ready,  m_mode == 1);
            chk("out_valid", out_valid, m_mode == 3);
            chk("byte_en",   byte_en,   e_load || e_data || (m_mode == 3 && out_ready));
            chk("ark_en",    ark_en,    e_load || e_data);
            chk("key_step",  key_step,  e_load || e_data);
            chk("sbox_sel",  sbox_sel,  (m_mode == 2) && (ph >= 16));
            chk("mix_en",    mix_en,    e_data && (ph % 4 == 3) && (e_round < 10));
            chk("round",     round,     e_round);
            chk("rcon",      rcon,      RCON_TAB[e_round]);
            chk("done",      done,      m_done);
            if (m_mode == 2 && m_n == 0)   chk("rcon_round1", rcon, 8'h01);
            if (m_mode == 2 && m_n == 160) chk("rcon_round9", rcon, 8'h1b);
            if (m_mode == 2 && m_n == 180) begin
                chk("rcon_round10", rcon, 8'h36);
                chk("round10", round, 4'd10);
            end
            if (in_ready && in_valid) t_last_in = cyc;
            if (out_valid && t_first_out < 0) t_first_out = cyc;
            if (out_valid && out_ready) xfer_cnt++;
            if (mix_en) mix_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic clear_metrics();
        t_last_in = 0; t_first_out = -1; mix_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    endtask

    task automatic run_block(input int ci, input int co, input bit noise);
        bit got;
        got = 1'b0;
        cfg_in = ci; cfg_out = co; cfg_noise = noise;
        stall_left = 5; pat_idx = 0;
        clear_metrics();
        req_start = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk); #1;
            if (done) begin got = 1'b1; break; end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL done_timeout cycle %0d: got no done, expected done within 4000 cycles", cyc);
        end
        // Cycles spent in ROUND between last input transfer and first output byte.
        chk("latency",  t_first_out - t_last_in - 1, 200);
        chk("mix_cnt",  mix_cnt, 36);
        chk("xfer_cnt", xfer_cnt, 16);
        chk("done_cnt", done_cnt, 1);
        $display("block in=%0d out=%0d noise=%0d: latency=%0d mix=%0d xfers=%0d done=%0d",
                 ci, co, noise, t_first_out - t_last_in - 1, mix_cnt, xfer_cnt, done_cnt);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        @(posedge clk); #1;
        checking = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rcon", rcon, 8'h01);
        chk("rst_round", round, 4'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_block(0, 0, 1'b0);
        run_block(2, 2, 1'b1);

        // Reset in round 5, phase 12.
        cfg_in = 0; cfg_out = 0; cfg_noise = 1'b1;
        req_start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk); #1;
            if (m_mode == 2 && m_n == 92) begin hit = 1'b1; break; end
        end
        chk("reach_r5p12", hit, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rcon", rcon, 8'h01);
        chk("midrst_round", round, 4'd0);
        chk("midrst_sbox", sbox_sel, 1'b0);
        $display("mid-round reset: busy=%0d rcon=%0h round=%0d", busy, rcon, round);
        repeat (3) @(posedge clk);

        run_block(0, 0, 1'b0);
        run_block(1, 1, 1'b1);
        run_block(1, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control sequencer for the 8-bit serial AES-128 encryption datapath. It accepts a 16-byte plaintext block over a valid/ready byte stream and steps the datapath through the initial AddRoundKey and rounds 1–10. It time-shares the single datapath S-box between the state bytes and the key schedule, then streams out the 16 ciphertext bytes. It sits beside the key-expansion controller and owns round numbering and Rcon generation for the whole core.

## Interface
Parameters:
- NUM_ROUNDS, 10: rounds after the initial AddRoundKey (AES-128).
- ROUND_CYCLES, 20: cycles per round, made of 16 data-byte cycles and 4 key S-box cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a block; sampled only in IDLE.
- in_valid  in  1  plaintext byte valid.
- in_ready  out  1  sequencer accepts a plaintext byte.
- out_valid  out  1  ciphertext byte valid on datapath output.
- out_ready  in  1  downstream accepts a ciphertext byte.
- byte_en  out  1  datapath shifts and processes one state byte this cycle.
- ark_en  out  1  XOR the round-key byte into the state byte.
- sbox_sel  out  1  shared S-box input: 0 selects the state byte, 1 selects the key-schedule word byte.
- mix_en  out  1  MixColumns on the column just completed.
- key_step  out  1  advance key expansion by one byte.
- rcon  out  8  current round constant.
- round  out  4  current round, 0 to 10.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final ciphertext byte transfers.

## Operation
- FSM states: IDLE, LOAD, ROUND, UNLOAD.
- IDLE:
  - All strobes are low.
  - start=1 moves to LOAD, with byte counter 0, round 0 and rcon 8'h01.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready handshake asserts byte_en, ark_en and key_step (initial AddRoundKey) and increments the byte counter.
  - in_valid=0 stalls: no strobes, counter holds.
  - The 16th transfer moves to ROUND with round=1 and phase=0.
- ROUND, phase counter 0–19:
  - Phases 0–15: byte_en=1, ark_en=1, key_step=1, sbox_sel=0.
  - mix_en=1 at phases 3, 7, 11 and 15 when round<10; mix_en=0 throughout round 10.
  - Phases 16–19: sbox_sel=1 (RotWord/SubWord for the next key), byte_en=0, key_step=0.
  - At phase 19:
    - If round<10: round increments, rcon advances by xtime (01,02,04,…,80,1b,36), phase returns to 0.
    - If round=10: go to UNLOAD.
- UNLOAD:
  - out_valid=1.
  - Each out_valid&&out_ready handshake asserts byte_en and increments the byte counter.
  - out_ready=0 holds everything.
  - The 16th transfer goes to IDLE and pulses done.
- start outside IDLE is ignored; there is no queuing.
- rcon, round and the counters are reloaded only on leaving IDLE.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, out_valid, byte_en, ark_en, sbox_sel, mix_en, key_step, busy and done all 0.
  - rcon 8'h01, round 0, counters 0.
- rst has priority over every state. Asserted mid-block, rst returns the sequencer to IDLE on the next edge and drops all strobes; the partial block is discarded.
- Control outputs are combinational from state and counters and are valid in the same cycle as the counter value.
- in_ready is not gated by in_valid.
- start is accepted at edge t: busy=1 and in_ready=1 from cycle t+1.
- Latency from the 16th input transfer to the first out_valid is exactly 200 cycles (10×20). This requires no stalls.
- With out_ready held high, done fires 16 cycles after the first out_valid cycle.
- A new start is accepted on the cycle after done, so there is no dead cycle beyond the IDLE visit.
- The byte counter is 4 bits and wraps 15→0 exactly at the state transition.
- The phase counter is 5 bits and never exceeds 19.

## Structure
- Shared package aes_seq_pkg holds:
  - state encodings IDLE=0, LOAD=1, ROUND=2, UNLOAD=3;
  - constants NUM_ROUNDS, ROUND_CYCLES, DATA_CYCLES=16, RCON_INIT=8'h01;
  - function xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
- One sub-module, aes_rcon_gen: an 8-bit register with load (to 8'h01) and step (to xtime) inputs, reused by the key-expansion controller.

## Test plan
- FIPS-197 C.1 vector: key 000102…0f, plaintext 00112233…ff, start, all handshakes always ready. Required: ciphertext 69c4e0d8…70b4c55a, first out_valid 200 cycles after the last input, done exactly once.
- rcon/round trace: rcon reads 01,02,04,08,10,20,40,80,1b,36 in rounds 1–10. mix_en pulses 36 times total, with none in round 10.
- Input stall: in_valid low for 5 cycles after byte 7. Required: byte counter and strobes hold, the result matches the C.1 output, and the latency is measured from the last transfer.
- Output backpressure: out_ready toggles 1,0,0,1 repeatedly. Required: 16 transfers, no byte dropped or duplicated, done only after the 16th.
- Reset mid-round: rst in round 5, phase 12. Required: next cycle IDLE with all outputs at reset values and rcon=01. A following C.1 block passes.
- start while busy during ROUND is ignored, with no effect on round or rcon. Back-to-back blocks, with start on the cycle after done, both produce correct ciphertext.
